// File: rtl/la_stream_unpacker.sv
// la_stream_unpacker: width downsizer for a valid/ready stream.
// Each accepted wide beat of IW bits leaves as up to IW/OW narrow beats of OW bits.
// The output is registered. A new wide beat can be accepted on the same edge that
// the last narrow beat of the previous one is taken, so a continuous input stream
// produces a continuous output stream.
module la_stream_unpacker #(
    parameter int IW            = 32,
    parameter int OW            = 8,
    parameter int OPT_LSB_FIRST = 1,
    parameter int OPT_LOWPOWER  = 0,
    localparam int RATIO        = IW / OW,
    localparam int CW           = $clog2(RATIO + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [IW-1:0] i_data,
    input  logic [CW-1:0] i_cnt,
    input  logic          i_last,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_last
);

    // Count of narrow beats still owed, including the one on the output (0 = empty).
    logic [CW-1:0] rem;
    // Lanes of the current wide beat that have not been presented yet.
    logic [IW-1:0] sreg;
    // i_last of the beat currently being unpacked.
    logic          held_last;
    logic [CW-1:0] eff_cnt;
    logic          accept;
    logic          out_hs;
    logic [OW-1:0] first_lane;
    logic [OW-1:0] next_lane;
    logic [IW-1:0] load_shift;
    logic [IW-1:0] adv_shift;

    // A lane count of zero, or any count larger than the beat holds, means a full beat.
    always_comb begin
        eff_cnt = i_cnt;
        if (i_cnt == '0 || i_cnt > CW'(RATIO)) begin
            eff_cnt = CW'(RATIO);
        end
    end

    // Lane selection. When the most significant lane goes first, a partial beat keeps
    // its valid lanes in the top of the word. Shifting left then walks down through
    // exactly those lanes.
    generate
        if (OPT_LSB_FIRST != 0) begin : g_lsb_first
            assign first_lane = i_data[OW-1:0];
            assign load_shift = i_data >> OW;
            assign next_lane  = sreg[OW-1:0];
            assign adv_shift  = sreg >> OW;
        end else begin : g_msb_first
            assign first_lane = i_data[IW-1 -: OW];
            assign load_shift = i_data << OW;
            assign next_lane  = sreg[IW-1 -: OW];
            assign adv_shift  = sreg << OW;
        end
    endgenerate

    // Take a new beat when empty, or when the final narrow beat is leaving right now.
    assign o_ready = i_reset_n && (rem == '0 || (rem == CW'(1) && i_ready));
    assign accept  = i_valid && o_ready;
    assign out_hs  = o_valid && i_ready;

    // Load a new wide beat, advance to the next lane, or go idle after the final lane.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_last    <= 1'b0;
            sreg      <= '0;
            rem       <= '0;
            held_last <= 1'b0;
        end else if (accept) begin
            o_valid   <= 1'b1;
            o_data    <= first_lane;
            sreg      <= load_shift;
            rem       <= eff_cnt;
            held_last <= i_last;
            o_last    <= i_last && (eff_cnt == CW'(1));
        end else if (out_hs) begin
            if (rem > CW'(1)) begin
                o_data <= next_lane;
                sreg   <= adv_shift;
                rem    <= rem - CW'(1);
                o_last <= held_last && (rem == CW'(2));
            end else begin
                o_valid <= 1'b0;
                rem     <= '0;
                o_last  <= 1'b0;
                if (OPT_LOWPOWER != 0) begin
                    o_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_la_stream_unpacker.sv
// tb_la_stream_unpacker: directed tests of la_stream_unpacker.
// All three instances receive the same inputs:
//   dut_a: LSB-first, normal power
//   dut_b: MSB-first
//   dut_c: LSB-first with low-power output zeroing
module tb_la_stream_unpacker;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        last;
    logic        ready_in;

    logic        a_ready, a_valid, a_last;
    logic [7:0]  a_data;
    logic        b_ready, b_valid, b_last;
    logic [7:0]  b_data;
    logic        c_ready, c_valid, c_last;
    logic [7:0]  c_data;

    int total;
    int bad;

    la_stream_unpacker #(.IW(32), .OW(8), .OPT_LSB_FIRST(1), .OPT_LOWPOWER(0)) dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .o_ready(a_ready),
        .i_data(data), .i_cnt(cnt), .i_last(last), .o_valid(a_valid),
        .i_ready(ready_in), .o_data(a_data), .o_last(a_last)
    );

    la_stream_unpacker #(.IW(32), .OW(8), .OPT_LSB_FIRST(0), .OPT_LOWPOWER(0)) dut_b (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .o_ready(b_ready),
        .i_data(data), .i_cnt(cnt), .i_last(last), .o_valid(b_valid),
        .i_ready(ready_in), .o_data(b_data), .o_last(b_last)
    );

    la_stream_unpacker #(.IW(32), .OW(8), .OPT_LSB_FIRST(1), .OPT_LOWPOWER(1)) dut_c (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .o_ready(c_ready),
        .i_data(data), .i_cnt(cnt), .i_last(last), .o_valid(c_valid),
        .i_ready(ready_in), .o_data(c_data), .o_last(c_last)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move one clock edge forward and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs are held in reset, then idle and ready once reset is released.
    task automatic test_reset();
        reset_n  = 1'b0;
        valid    = 1'b0;
        data     = '0;
        cnt      = '0;
        last     = 1'b0;
        ready_in = 1'b1;
        step();
        step();
        total++;
        if ({a_valid, a_data, a_last, a_ready} !== 11'h000) begin
            bad++;
            $display("[TB] FAIL reset_held: got v=%b d=%h l=%b r=%b want all zero",
                     a_valid, a_data, a_last, a_ready);
        end
        #2 reset_n = 1'b1;
        step();
        total++;
        if ({a_valid, a_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL reset_release: got v=%b r=%b want v=0 r=1", a_valid, a_ready);
        end
    endtask

    // A full beat comes out lane 0 first. Ready returns only while the final lane is shown.
    task automatic test_full_beat();
        logic [7:0] lanes [4];
        lanes[0] = 8'hAA; lanes[1] = 8'hBB; lanes[2] = 8'hCC; lanes[3] = 8'hDD;
        valid = 1'b1; data = 32'hDDCCBBAA; cnt = 3'd0; last = 1'b0;
        step();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({a_valid, a_data, a_last, a_ready} !== {1'b1, lanes[k], 1'b0, (k == 3)}) begin
                bad++;
                $display("[TB] FAIL full_beat[%0d]: got v=%b d=%h l=%b r=%b want v=1 d=%h l=0 r=%b",
                         k, a_valid, a_data, a_last, a_ready, lanes[k], (k == 3));
            end
            step();
        end
        total++;
        if ({a_valid, a_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL full_beat_idle: got v=%b r=%b want v=0 r=1", a_valid, a_ready);
        end
    endtask

    // Two beats in a row give eight narrow beats with no gap between them.
    task automatic test_back_to_back();
        logic [7:0] lanes [8];
        for (int k = 0; k < 8; k++) lanes[k] = 8'(8'h11 * (k + 1));
        valid = 1'b1; data = 32'h44332211; cnt = 3'd0; last = 1'b0;
        step();
        data = 32'h88776655;
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({a_valid, a_data, a_last, a_ready} !==
                {1'b1, lanes[k], 1'b0, (k == 3 || k == 7)}) begin
                bad++;
                $display("[TB] FAIL back_to_back[%0d]: got v=%b d=%h l=%b r=%b want v=1 d=%h l=0 r=%b",
                         k, a_valid, a_data, a_last, a_ready, lanes[k], (k == 3 || k == 7));
            end
            if (k == 4) valid = 1'b0;
            step();
        end
        total++;
        if (a_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL back_to_back_idle: got v=%b want 0", a_valid);
        end
    endtask

    // A three-lane packet end: the junk top lane is dropped and last marks lane 33.
    // The low-power instance zeroes its outputs once it goes idle.
    task automatic test_partial_last();
        logic [7:0] lanes [3];
        lanes[0] = 8'h11; lanes[1] = 8'h22; lanes[2] = 8'h33;
        valid = 1'b1; data = 32'hFF332211; cnt = 3'd3; last = 1'b1;
        step();
        valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({a_valid, a_data, a_last} !== {1'b1, lanes[k], (k == 2)}) begin
                bad++;
                $display("[TB] FAIL partial_last[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, a_valid, a_data, a_last, lanes[k], (k == 2));
            end
            step();
        end
        total++;
        if ({a_valid, a_last} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL partial_idle: got v=%b l=%b want 0 0", a_valid, a_last);
        end
        total++;
        if ({c_valid, c_data, c_last} !== 10'h000) begin
            bad++;
            $display("[TB] FAIL lowpower_idle: got v=%b d=%h l=%b want all zero",
                     c_valid, c_data, c_last);
        end
    endtask

    // A count above the lane total means a full beat. A count of one ends the beat at once.
    task automatic test_cnt_bounds();
        logic [7:0] lanes [4];
        lanes[0] = 8'h01; lanes[1] = 8'h02; lanes[2] = 8'h03; lanes[3] = 8'h04;
        valid = 1'b1; data = 32'h04030201; cnt = 3'd7; last = 1'b1;
        step();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({a_valid, a_data, a_last} !== {1'b1, lanes[k], (k == 3)}) begin
                bad++;
                $display("[TB] FAIL cnt_over[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, a_valid, a_data, a_last, lanes[k], (k == 3));
            end
            step();
        end
        valid = 1'b1; data = 32'h123456EE; cnt = 3'd1; last = 1'b1;
        step();
        valid = 1'b0;
        total++;
        if ({a_valid, a_data, a_last, a_ready} !== {1'b1, 8'hEE, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL cnt_one: got v=%b d=%h l=%b r=%b want v=1 d=ee l=1 r=1",
                     a_valid, a_data, a_last, a_ready);
        end
        step();
        total++;
        if (a_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cnt_one_idle: got v=%b want 0", a_valid);
        end
    endtask

    // Backpressure while BB is shown holds everything still. CC follows one edge after release.
    task automatic test_stall();
        valid = 1'b1; data = 32'hDDCCBBAA; cnt = 3'd0; last = 1'b0;
        step();
        valid = 1'b0;
        step();
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({a_valid, a_data, a_last, a_ready} !== {1'b1, 8'hBB, 1'b0, 1'b0}) begin
                bad++;
                $display("[TB] FAIL stall[%0d]: got v=%b d=%h l=%b r=%b want v=1 d=bb l=0 r=0",
                         k, a_valid, a_data, a_last, a_ready);
            end
            step();
        end
        ready_in = 1'b1;
        step();
        total++;
        if ({a_valid, a_data} !== {1'b1, 8'hCC}) begin
            bad++;
            $display("[TB] FAIL stall_resume: got v=%b d=%h want v=1 d=cc", a_valid, a_data);
        end
        step();
        step();
        total++;
        if (a_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_idle: got v=%b want 0", a_valid);
        end
    endtask

    // Reset in the middle of a beat throws away the lanes that have not been sent.
    task automatic test_reset_midbeat();
        valid = 1'b1; data = 32'hDDCCBBAA; cnt = 3'd0; last = 1'b0;
        step();
        valid = 1'b0;
        step();
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({a_valid, a_ready} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL midbeat_async: got v=%b r=%b want 0 0", a_valid, a_ready);
        end
        step();
        #2 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({a_valid, a_ready} !== 2'b01) begin
                bad++;
                $display("[TB] FAIL midbeat_after[%0d]: got v=%b r=%b d=%h want v=0 r=1",
                         k, a_valid, a_ready, a_data);
            end
        end
    endtask

    // MSB-first instance: a full beat goes out DD first. A two-lane beat sends the top two lanes.
    task automatic test_msb_first();
        logic [7:0] lanes [4];
        lanes[0] = 8'hDD; lanes[1] = 8'hCC; lanes[2] = 8'hBB; lanes[3] = 8'hAA;
        valid = 1'b1; data = 32'hDDCCBBAA; cnt = 3'd0; last = 1'b0;
        step();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({b_valid, b_data, b_last} !== {1'b1, lanes[k], 1'b0}) begin
                bad++;
                $display("[TB] FAIL msb_full[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=0",
                         k, b_valid, b_data, b_last, lanes[k]);
            end
            step();
        end
        valid = 1'b1; data = 32'hDDCCBBAA; cnt = 3'd2; last = 1'b1;
        step();
        valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({b_valid, b_data, b_last} !== {1'b1, lanes[k], (k == 1)}) begin
                bad++;
                $display("[TB] FAIL msb_partial[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, b_valid, b_data, b_last, lanes[k], (k == 1));
            end
            step();
        end
        total++;
        if ({b_valid, b_last} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL msb_idle: got v=%b l=%b want 0 0", b_valid, b_last);
        end
    endtask

    // Run the test tasks in order, then print the summary line.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_full_beat();
        test_back_to_back();
        test_partial_last();
        test_cnt_bounds();
        test_stall();
        test_reset_midbeat();
        test_msb_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
